register_bank: RTL and testbench

Parametrised multi-entry register bank for the 8-bit CPU datapath.
- Holds DEPTH words of WIDTH bits, built from 8-bit lanes.
- One byte-enabled write port with a valid/ready handshake and two registered read ports.
- A multi-cycle flush sequencer zeroes the bank one entry per cycle.
- Replaces ad-hoc wide registers assembled from fixed 8-bit registers in the register-file and address-pair paths.

---
 rtl/register_bank_pkg.sv | 17 +
 rtl/register_lane.sv | 27 ++
 rtl/register_bank.sv | 123 ++++++++++++
 tb/tb_register_bank.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/register_bank_pkg.sv
// Shared types and helpers for the byte-laned register bank.
package register_bank_pkg;

  localparam int LANE_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } seq_state_e;

  function automatic logic [LANE_W-1:0] lane_merge(input logic [LANE_W-1:0] old_v,
                                                   input logic [LANE_W-1:0] new_v,
                                                   input logic              be);
    return be ? new_v : old_v;
  endfunction

endpackage

// File: rtl/register_lane.sv
// One 8-bit storage lane: load on en_i, synchronous zero on zero_i, async clear.
module register_lane
  import register_bank_pkg::*;
(
  input  logic              clock,
  input  logic              clear_n,
  input  logic              en_i,
  input  logic              zero_i,
  input  logic [LANE_W-1:0] d_i,
  output logic [LANE_W-1:0] q_o
);

  logic [LANE_W-1:0] data_q;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      data_q <= '0;
    end else if (zero_i) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/register_bank.sv
// Byte-enabled register bank with two registered read ports and a flush sweeper.
// Optional same-edge write-to-read forwarding: define REGISTER_BANK_BYPASS_EN.
module register_bank
  import register_bank_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LANES = WIDTH / LANE_W
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             clock_enable,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [LANES-1:0] wr_be,
  input  logic             rd_en_a,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic             rd_en_b,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
  input  logic             flush,
  output logic             busy
);

  seq_state_e        state_q;
  logic [AW-1:0]     ptr_q;
  logic [WIDTH-1:0]  rd_data_a_q, rd_data_b_q;
  logic [WIDTH-1:0]  rd_word_a, rd_word_b;
  logic [LANE_W-1:0] lane_q [DEPTH][LANES];
  logic              wr_fire;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  assign busy     = (state_q == SWEEP);
  assign wr_ready = clock_enable & ~busy;
  assign wr_fire  = wr_valid & wr_ready;

  // Out-of-range write addresses match no entry, so they are dropped here.
  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      register_lane u_lane (
        .clock  (clock),
        .clear_n(clear_n),
        .en_i   (wr_fire & (wr_addr == AW'(e))),
        .zero_i (clock_enable & busy & (ptr_q == AW'(e))),
        .d_i    (lane_merge(lane_q[e][l], wr_data[l*LANE_W +: LANE_W], wr_be[l])),
        .q_o    (lane_q[e][l])
      );
    end
  end

  always_comb begin
    rd_word_a = '0;
    rd_word_b = '0;
    if (addr_ok(rd_addr_a)) begin
      for (int l = 0; l < LANES; l++) rd_word_a[l*LANE_W +: LANE_W] = lane_q[rd_addr_a][l];
    end
    if (addr_ok(rd_addr_b)) begin
      for (int l = 0; l < LANES; l++) rd_word_b[l*LANE_W +: LANE_W] = lane_q[rd_addr_b][l];
    end
`ifdef REGISTER_BANK_BYPASS_EN
    if (wr_fire && addr_ok(wr_addr) && (wr_addr == rd_addr_a)) begin
      for (int l = 0; l < LANES; l++)
        rd_word_a[l*LANE_W +: LANE_W] = lane_merge(rd_word_a[l*LANE_W +: LANE_W],
                                                   wr_data[l*LANE_W +: LANE_W], wr_be[l]);
    end
    if (wr_fire && addr_ok(wr_addr) && (wr_addr == rd_addr_b)) begin
      for (int l = 0; l < LANES; l++)
        rd_word_b[l*LANE_W +: LANE_W] = lane_merge(rd_word_b[l*LANE_W +: LANE_W],
                                                   wr_data[l*LANE_W +: LANE_W], wr_be[l]);
    end
`endif
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
    end else if (clock_enable) begin
      if (rd_en_a) rd_data_a_q <= rd_word_a;
      if (rd_en_b) rd_data_b_q <= rd_word_b;
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;

  // Flush arriving mid-sweep is ignored; the sweep always runs 0..DEPTH-1.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else if (clock_enable) begin
      case (state_q)
        IDLE: begin
          if (flush) begin
            state_q <= SWEEP;
            ptr_q   <= '0;
          end
        end
        SWEEP: begin
          if (ptr_q == AW'(DEPTH - 1)) begin
            state_q <= IDLE;
            ptr_q   <= '0;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ptr_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// Directed vector bench for register_bank (DEPTH=8 and DEPTH=6 instances).
module tb_register_bank;

  logic clock = 1'b0;
  logic clear_n;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

`ifdef REGISTER_BANK_BYPASS_EN
  localparam logic [15:0] SAME_EDGE = 16'hA5A5;
`else
  localparam logic [15:0] SAME_EDGE = 16'h1111;
`endif

  // DEPTH=8 instance
  logic        ce8, wv8, wr8, rea8, reb8, fl8, busy8;
  logic [2:0]  wa8, ra8, rb8;
  logic [15:0] wd8, da8, db8;
  logic [1:0]  be8;

  register_bank #(.WIDTH(16), .DEPTH(8)) u_dut8 (
    .clock(clock), .clear_n(clear_n), .clock_enable(ce8),
    .wr_valid(wv8), .wr_ready(wr8), .wr_addr(wa8), .wr_data(wd8), .wr_be(be8),
    .rd_en_a(rea8), .rd_addr_a(ra8), .rd_data_a(da8),
    .rd_en_b(reb8), .rd_addr_b(rb8), .rd_data_b(db8),
    .flush(fl8), .busy(busy8)
  );

  // DEPTH=6 instance
  logic        ce6, wv6, wr6, rea6, reb6, fl6, busy6;
  logic [2:0]  wa6, ra6, rb6;
  logic [15:0] wd6, da6, db6;
  logic [1:0]  be6;

  register_bank #(.WIDTH(16), .DEPTH(6)) u_dut6 (
    .clock(clock), .clear_n(clear_n), .clock_enable(ce6),
    .wr_valid(wv6), .wr_ready(wr6), .wr_addr(wa6), .wr_data(wd6), .wr_be(be6),
    .rd_en_a(rea6), .rd_addr_a(ra6), .rd_data_a(da6),
    .rd_en_b(reb6), .rd_addr_b(rb6), .rd_data_b(db6),
    .flush(fl6), .busy(busy6)
  );

  typedef struct {
    logic        wv;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [1:0]  be;
    logic        ra_en;
    logic [2:0]  ra;
    logic        rb_en;
    logic [2:0]  rb;
    logic [15:0] ea;
    logic [15:0] eb;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle8();
    wv8 = 0; rea8 = 0; reb8 = 0; fl8 = 0; wa8 = 0; ra8 = 0; rb8 = 0; wd8 = 0; be8 = 2'b11;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int cnt;
    clear_n = 0; ce8 = 1; ce6 = 1;
    idle8();
    wv6 = 0; rea6 = 0; reb6 = 0; fl6 = 0; wa6 = 0; ra6 = 0; rb6 = 0; wd6 = 0; be6 = 2'b11;

    vecs[0]  = '{1'b1, 3'd2, 16'hBEEF, 2'b11, 1'b1, 3'd3, 1'b1, 3'd3, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b1, 3'd2, 16'h12AB, 2'b10, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0000, 16'h0000};
    vecs[2]  = '{1'b0, 3'd0, 16'h0000, 2'b11, 1'b1, 3'd2, 1'b1, 3'd2, 16'h12EF, 16'h12EF};
    vecs[3]  = '{1'b1, 3'd5, 16'h1111, 2'b11, 1'b1, 3'd0, 1'b0, 3'd0, 16'h0000, 16'h12EF};
    vecs[4]  = '{1'b1, 3'd5, 16'hA5A5, 2'b11, 1'b1, 3'd5, 1'b1, 3'd5, SAME_EDGE, SAME_EDGE};
    vecs[5]  = '{1'b1, 3'd7, 16'h00CD, 2'b01, 1'b1, 3'd5, 1'b0, 3'd0, 16'hA5A5, SAME_EDGE};
    vecs[6]  = '{1'b1, 3'd7, 16'hEE00, 2'b10, 1'b0, 3'd0, 1'b1, 3'd2, 16'hA5A5, 16'h12EF};
    vecs[7]  = '{1'b1, 3'd7, 16'hFFFF, 2'b00, 1'b1, 3'd7, 1'b1, 3'd0, 16'hEECD, 16'h0000};
    vecs[8]  = '{1'b0, 3'd0, 16'h0000, 2'b11, 1'b1, 3'd7, 1'b1, 3'd5, 16'hEECD, 16'hA5A5};
    vecs[9]  = '{1'b0, 3'd1, 16'h9999, 2'b11, 1'b1, 3'd1, 1'b0, 3'd0, 16'h0000, 16'hA5A5};
    vecs[10] = '{1'b0, 3'd0, 16'h0000, 2'b11, 1'b0, 3'd0, 1'b1, 3'd1, 16'h0000, 16'h0000};

    // reset values
    tick(); tick();
    chk("reset_rd_a", da8, 16'h0000);
    chk("reset_rd_b", db8, 16'h0000);
    chk("reset_busy", {15'b0, busy8}, 16'h0000);
    chk("reset_wr_ready", {15'b0, wr8}, 16'h0001);
    #4 clear_n = 1;

    // table-driven write/read vectors
    for (int i = 0; i < 11; i++) begin
      wv8 = vecs[i].wv; wa8 = vecs[i].wa; wd8 = vecs[i].wd; be8 = vecs[i].be;
      rea8 = vecs[i].ra_en; ra8 = vecs[i].ra; reb8 = vecs[i].rb_en; rb8 = vecs[i].rb;
      tick();
      chk($sformatf("vec%0d_rd_a", i), da8, vecs[i].ea);
      chk($sformatf("vec%0d_rd_b", i), db8, vecs[i].eb);
    end

    // async reset mid-operation
    idle8(); rea8 = 1; ra8 = 2; reb8 = 1; rb8 = 5;
    tick();
    chk("pre_reset_rd_a", da8, 16'h12EF);
    chk("pre_reset_rd_b", db8, 16'hA5A5);
    idle8();
    #2 clear_n = 0;
    #1;
    chk("async_reset_rd_a", da8, 16'h0000);
    chk("async_reset_rd_b", db8, 16'h0000);
    chk("async_reset_busy", {15'b0, busy8}, 16'h0000);
    #1 clear_n = 1;
    rea8 = 1; ra8 = 3; reb8 = 1; rb8 = 2;
    tick();
    chk("post_reset_e3_a", da8, 16'h0000);
    chk("post_reset_e2_b", db8, 16'h0000);

    // fill then flush with write on flush edge and a second flush mid-sweep
    idle8();
    for (int i = 0; i < 8; i++) begin
      wv8 = 1; wa8 = 3'(i); wd8 = 16'hFFFF; be8 = 2'b11;
      tick();
    end
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      idle8();
      fl8  = (k == 0 || k == 3);
      wv8  = (k == 0 || k == 4);
      wa8  = (k == 0) ? 3'd1 : 3'd0;
      wd8  = (k == 0) ? 16'h0042 : 16'h1234;
      rea8 = (k == 1 || k == 2);
      ra8  = (k == 1) ? 3'd7 : 3'd0;
      reb8 = (k == 1);
      rb8  = 3'd1;
      tick();
      if (k == 1) begin
        chk("sweep_rd_e7", da8, 16'hFFFF);
        chk("sweep_rd_e1_flush_write", db8, 16'h0042);
      end
      if (k == 2) chk("sweep_rd_e0", da8, 16'h0000);
      if (busy8) begin
        cnt++;
        if (k == 4) chk("sweep_wr_ready_low", {15'b0, wr8}, 16'h0000);
      end else begin
        break;
      end
    end
    chk("flush8_busy_cycles", 16'(cnt), 16'd8);
    chk("flush8_wr_ready_after", {15'b0, wr8}, 16'h0001);
    idle8();
    for (int i = 0; i < 8; i++) begin
      rea8 = 1; ra8 = 3'(i); reb8 = 1; rb8 = 3'(7 - i);
      tick();
      chk($sformatf("post_flush_a_e%0d", i), da8, 16'h0000);
      chk($sformatf("post_flush_b_e%0d", 7 - i), db8, 16'h0000);
    end

    // DEPTH=6: clock_enable gating, out-of-range, stalled sweep
    ce6 = 0; wv6 = 1; wa6 = 5; wd6 = 16'h5555;
    tick();
    chk("ce_low_wr_ready", {15'b0, wr6}, 16'h0000);
    ce6 = 1;
    tick();
    wa6 = 7; wd6 = 16'hDEAD;
    tick();
    wv6 = 0; rea6 = 1; ra6 = 5;
    tick();
    chk("d6_rd_e5", da6, 16'h5555);
    ra6 = 7; reb6 = 1; rb6 = 1;
    tick();
    chk("d6_rd_oor7", da6, 16'h0000);
    chk("d6_rd_e1_no_alias", db6, 16'h0000);
    rea6 = 0; reb6 = 0;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      fl6 = (k == 0);
      ce6 = !(k >= 3 && k <= 5);
      tick();
      if (busy6) cnt++;
      else break;
    end
    ce6 = 1; fl6 = 0;
    chk("flush6_stall_busy_cycles", 16'(cnt), 16'd9);
    rea6 = 1; ra6 = 5;
    tick();
    chk("d6_post_flush_e5", da6, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
